noc_flit_packetizer: RTL

Injection-side network-interface block that turns a message request into a well-formed flit stream for a router local input port. A message is a destination (x, y, local port), a head payload, and 0..MAX_BEATS payload words. These become one HEADTAIL flit, or one HEAD flit, zero or more BODY flits and one TAIL flit, in `flit_t` format. The block sits between a DLA/host master and the router's local port, and is the transmit counterpart of the router's flit-consuming input logic.

---
 rtl/noc_flit_packetizer_pkg.sv | 56 +++++
 rtl/noc_flit_packetizer_if.sv | 32 +++
 rtl/noc_flit_out_reg.sv | 42 ++++
 rtl/noc_flit_packetizer.sv | 110 +++++++++++
 4 files changed

// File: rtl/noc_flit_packetizer_pkg.sv
// Shared NoC types for the injection-side packetizer: flit format, head fields,
// message request record and the FSM state encoding.
package noc_flit_packetizer_pkg;

  localparam int DEST_ADDR_SIZE_X  = 4;
  localparam int DEST_ADDR_SIZE_Y  = 4;
  localparam int DEST_ADDR_SIZE_L  = 3;
  localparam int HEAD_PAYLOAD_SIZE = 21;
  localparam int FLIT_DATA_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y +
                                     DEST_ADDR_SIZE_L + HEAD_PAYLOAD_SIZE;
  localparam int PKT_LEN_W         = 5;

  localparam logic [DEST_ADDR_SIZE_L-1:0] L_DEST_MAX = DEST_ADDR_SIZE_L'(4);

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [DEST_ADDR_SIZE_L-1:0]  l_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef union packed {
    head_data_t                head;
    logic [FLIT_DATA_SIZE-1:0] bt_pl;
  } flit_data_t;

  typedef struct packed {
    flit_label_t flit_label;
    flit_data_t  data;
  } flit_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [DEST_ADDR_SIZE_L-1:0]  l_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    logic [PKT_LEN_W-1:0]         len;
  } pkt_req_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } pkt_state_t;

  function automatic logic is_last(input flit_label_t label);
    return (label == TAIL) || (label == HEADTAIL);
  endfunction

endpackage

// File: rtl/noc_flit_packetizer_if.sv
// Request, payload and flit handshakes between host master, packetizer and router.
interface noc_flit_packetizer_if
  import noc_flit_packetizer_pkg::*;
#(
  parameter int LEN_W = 5
);
  logic                         req_valid;
  logic                         req_ready;
  logic [DEST_ADDR_SIZE_X-1:0]  req_x_dest;
  logic [DEST_ADDR_SIZE_Y-1:0]  req_y_dest;
  logic [DEST_ADDR_SIZE_L-1:0]  req_l_dest;
  logic [HEAD_PAYLOAD_SIZE-1:0] req_head_pl;
  logic [LEN_W-1:0]             req_len;
  logic                         pl_valid;
  logic                         pl_ready;
  logic [FLIT_DATA_SIZE-1:0]    pl_data;
  logic                         flit_valid;
  logic                         flit_ready;
  flit_t                        flit_o;

  modport master (
    output req_valid, req_x_dest, req_y_dest, req_l_dest, req_head_pl, req_len,
    output pl_valid, pl_data, flit_ready,
    input  req_ready, pl_ready, flit_valid, flit_o
  );

  modport slave (
    input  req_valid, req_x_dest, req_y_dest, req_l_dest, req_head_pl, req_len,
    input  pl_valid, pl_data, flit_ready,
    output req_ready, pl_ready, flit_valid, flit_o
  );
endinterface

// File: rtl/noc_flit_out_reg.sv
// Single-entry valid/ready flit register; a load may coincide with the
// downstream handshake so back-to-back flits leave without a bubble.
module noc_flit_out_reg
  import noc_flit_packetizer_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  flit_t load_flit,
  input  logic  out_ready,
  output logic  out_valid,
  output flit_t out_flit,
  output logic  free
);
  logic  valid_q, valid_d;
  flit_t flit_q, flit_d;

  assign free      = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_flit  = flit_q;

  always_comb begin
    valid_d = valid_q;
    flit_d  = flit_q;
    if (load) begin
      valid_d = 1'b1;
      flit_d  = load_flit;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      flit_q  <= '0;
    end else begin
      valid_q <= valid_d;
      flit_q  <= flit_d;
    end
  end
endmodule

// File: rtl/noc_flit_packetizer.sv
// Turns a message request plus payload words into a HEAD/BODY/TAIL (or single
// HEADTAIL) flit stream for a router local input port.
module noc_flit_packetizer
  import noc_flit_packetizer_pkg::*;
#(
  parameter int MAX_BEATS = 16,
  parameter int LEN_W     = $clog2(MAX_BEATS + 1),
  parameter int CNT_W     = 16
)(
  input  logic                 clk,
  input  logic                 rst_n,
  noc_flit_packetizer_if.slave bus,
  output logic                 busy,
  output logic                 err,
  output logic [CNT_W-1:0]     pkt_cnt
);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BEATS);

  pkt_state_t       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic             free, load, req_hs, pl_hs, out_hs, req_bad;
  flit_t            load_flit;

  // Readies are gated by rst_n so nothing is accepted while reset is held.
  assign bus.req_ready = rst_n && free && (state_q == IDLE);
  assign bus.pl_ready  = rst_n && free && (state_q == PAYLOAD);

  assign req_hs  = bus.req_valid && bus.req_ready;
  assign pl_hs   = bus.pl_valid && bus.pl_ready;
  assign out_hs  = bus.flit_valid && bus.flit_ready;
  assign req_bad = (bus.req_len > MAX_LEN) || (bus.req_l_dest > L_DEST_MAX);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    load      = 1'b0;
    load_flit = '0;
    unique case (state_q)
      IDLE: begin
        if (req_hs) begin
          load                   = 1'b1;
          load_flit.data.head    = '{x_dest:  bus.req_x_dest,
                                     y_dest:  bus.req_y_dest,
                                     l_dest:  bus.req_l_dest,
                                     head_pl: bus.req_head_pl};
          if (bus.req_len == '0) begin
            load_flit.flit_label = HEADTAIL;
          end else begin
            load_flit.flit_label = HEAD;
            rem_d                = (bus.req_len > MAX_LEN) ? MAX_LEN : bus.req_len;
            state_d              = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (pl_hs) begin
          load                 = 1'b1;
          load_flit.data.bt_pl = bus.pl_data;
          rem_d                = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            load_flit.flit_label = TAIL;
            state_d              = IDLE;
          end else begin
            load_flit.flit_label = BODY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_d     = err_q || (req_hs && req_bad);
    pkt_cnt_d = pkt_cnt_q;
    if (out_hs && is_last(bus.flit_o.flit_label)) begin
      pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      err_q     <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  noc_flit_out_reg u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_flit (load_flit),
    .out_ready (bus.flit_ready),
    .out_valid (bus.flit_valid),
    .out_flit  (bus.flit_o),
    .free      (free)
  );

  assign busy    = (state_q == PAYLOAD) || bus.flit_valid;
  assign err     = err_q;
  assign pkt_cnt = pkt_cnt_q;
endmodule
